// File: rtl/riscv_pkg.sv
// Shared constants for the execute stage: ALU ops, branch types, skid-buffer
// states and the buffered result entry.
package riscv_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam int ST_EQ  = 0;
  localparam int ST_LT  = 1;
  localparam int ST_LTU = 2;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb_en;
  } ex_entry_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from the ALU compare status bits.
module branch_resolve
  import riscv_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic [2:0] status,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken =  status[ST_EQ];
      BR_BNE:  taken = !status[ST_EQ];
      BR_BLT:  taken =  status[ST_LT];
      BR_BGE:  taken = !status[ST_LT];
      BR_BLTU: taken =  status[ST_LTU];
      BR_BGEU: taken = !status[ST_LTU];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute issue stage: drives the external ALU, resolves branches and holds
// results in a 2-entry skid buffer so id_ready stays a flop output.
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_alu_op,
  input  logic        id_use_imm,
  input  logic        id_is_branch,
  input  logic [2:0]  id_br_type,
  input  logic [4:0]  id_rd,
  input  logic        id_wb_en,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic [2:0]  alu_status,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_result,
  output logic [4:0]  ex_rd,
  output logic        ex_wb_en,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  skid_state_e state_q, state_d;
  ex_entry_t   head_q, tail_q, new_ent;
  logic        rdy_q;
  logic [31:0] opnd_b;
  logic        br_taken, accept, push, pop, take_redirect;

  // Shifts swap operands: the ALU reads the shift amount from alu_a[4:0].
  always_comb begin
    opnd_b = id_use_imm ? id_imm : id_rs2_val;
    alu_op = id_alu_op;
    alu_a  = id_rs1_val;
    alu_b  = opnd_b;
    if (id_is_branch) begin
      alu_op = OP_SUB;
      alu_b  = id_rs2_val;
    end else if (is_shift(id_alu_op)) begin
      alu_a = opnd_b;
      alu_b = id_rs1_val;
    end
  end

  branch_resolve u_br (
    .br_type (id_br_type),
    .status  (alu_status),
    .taken   (br_taken)
  );

  // Accepts during a redirect pulse are wrong-path: handshake completes, entry is dropped.
  assign accept        = id_valid && rdy_q;
  assign push          = accept && !redirect_valid && !flush;
  assign pop           = ex_valid && ex_ready;
  assign take_redirect = push && id_is_branch && br_taken;

  always_comb begin
    new_ent.rd     = id_rd;
    new_ent.result = id_is_branch ? 32'd0 : alu_out;
    new_ent.wb_en  = id_is_branch ? 1'b0  : id_wb_en;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SK_EMPTY;
    end else begin
      case (state_q)
        SK_EMPTY: if (push) state_d = SK_ONE;
        SK_ONE: begin
          if (push && !pop)      state_d = SK_FULL;
          else if (pop && !push) state_d = SK_EMPTY;
        end
        SK_FULL:  if (pop) state_d = SK_ONE;
        default:  state_d = SK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SK_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != SK_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      case (state_q)
        SK_EMPTY: if (push) head_q <= new_ent;
        SK_ONE: begin
          if (push && pop) head_q <= new_ent;
          else if (push)   tail_q <= new_ent;
        end
        SK_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= take_redirect;
      if (take_redirect) redirect_pc <= id_pc + id_imm;
    end
  end

  assign id_ready  = rdy_q;
  assign ex_valid  = (state_q != SK_EMPTY);
  assign ex_result = head_q.result;
  assign ex_rd     = head_q.rd;
  assign ex_wb_en  = head_q.wb_en;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a queue-based reference model,
// with an ALU model closing the combinational loop.
module tb_alu_issue_stage;
  import riscv_pkg::*;

  logic clk, rst_n, flush;
  logic id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [2:0]  id_alu_op, id_br_type;
  logic id_use_imm, id_is_branch, id_wb_en;
  logic [4:0]  id_rd;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op, alu_status;
  logic ex_valid, ex_ready, ex_wb_en, redirect_valid;
  logic [31:0] ex_result, redirect_pc;
  logic [4:0]  ex_rd;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_is_branch(id_is_branch),
    .id_br_type(id_br_type), .id_rd(id_rd), .id_wb_en(id_wb_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: shift amount from alu_a[4:0], shifted value alu_b.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_SLL:  alu_out = alu_b << alu_a[4:0];
      OP_SRL:  alu_out = alu_b >> alu_a[4:0];
      default: alu_out = $unsigned($signed(alu_b) >>> alu_a[4:0]);
    endcase
    alu_status = {alu_a < alu_b, $signed(alu_a) < $signed(alu_b), alu_a == alu_b};
  end

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  ent_t        mq[$];
  logic        m_rv;
  logic [31:0] m_pc;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLL:  return x << y[4:0];
      OP_SRL:  return x >> y[4:0];
      default: return $unsigned($signed(x) >>> y[4:0]);
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] bt, input logic [31:0] x, input logic [31:0] y);
    case (bt)
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd4:    return $signed(x) < $signed(y);
      3'd5:    return $signed(x) >= $signed(y);
      3'd6:    return x < y;
      3'd7:    return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic compare();
    chk("ex_valid", ex_valid, mq.size() != 0);
    chk("id_ready", id_ready, mq.size() < 2);
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) chk("redirect_pc", redirect_pc, m_pc);
    if (mq.size() != 0) begin
      chk("ex_result", ex_result, mq[0].r);
      chk("ex_rd", ex_rd, mq[0].rd);
      chk("ex_wb_en", ex_wb_en, mq[0].wb);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic acc, psh;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_rv = 1'b0; m_pc = '0;
    end else begin
      acc = id_valid && (mq.size() < 2);
      psh = acc && !m_rv && !flush;
      if (flush) begin
        mq.delete(); m_rv = 1'b0;
      end else begin
        if (mq.size() != 0 && ex_ready) void'(mq.pop_front());
        if (psh) begin
          e.rd = id_rd;
          e.r  = id_is_branch ? 32'd0 : ref_alu(id_alu_op, id_rs1_val, id_use_imm ? id_imm : id_rs2_val);
          e.wb = id_is_branch ? 1'b0 : id_wb_en;
          mq.push_back(e);
        end
        m_rv = psh && id_is_branch && ref_taken(id_br_type, id_rs1_val, id_rs2_val);
        if (m_rv) m_pc = id_pc + id_imm;
      end
    end
    #1 compare();
    @(negedge clk);
  endtask

  task automatic ins(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] imm, input logic ui, input logic [4:0] rd, input logic wb);
    id_valid = 1'b1; id_alu_op = op; id_rs1_val = rs1; id_rs2_val = rs2; id_imm = imm;
    id_use_imm = ui; id_is_branch = 1'b0; id_br_type = 3'd0; id_pc = 32'h40; id_rd = rd; id_wb_en = wb;
  endtask

  task automatic br(input logic [2:0] bt, input logic [31:0] rs1, input logic [31:0] rs2,
                    input logic [31:0] pc, input logic [31:0] imm);
    ins(OP_ADD, rs1, rs2, imm, 1'b0, 5'd0, 1'b0);
    id_is_branch = 1'b1; id_br_type = bt; id_pc = pc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_id_ready"}, id_ready, 1);
    chk({tag, "_ex_valid"}, ex_valid, 0);
    chk({tag, "_ex_result"}, ex_result, 0);
    chk({tag, "_ex_rd"}, ex_rd, 0);
    chk({tag, "_ex_wb_en"}, ex_wb_en, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
  endtask

  initial begin
    mq.delete(); m_rv = 1'b0; m_pc = '0;
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    ins(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b1, 5'd1, 1'b1);
    #2 rst_n = 1'b0;
    // Reset held with a live offer: nothing may be pushed.
    repeat (3) step();
    chk_reset_outputs("rst");
    id_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic arithmetic and the shift operand swap.
    ins(OP_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3, 1'b1);
    step();
    chk("add_result", ex_result, 32'd12);
    ins(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd4, 1'b1);
    step();
    chk("sra_result", ex_result, 32'hF800_0000);
    id_valid = 1'b0;
    step();

    // Backpressure: three offers, two accepted.
    ex_ready = 1'b0;
    ins(OP_ADD, 32'd10, 32'd0, 32'd1, 1'b1, 5'd5, 1'b1); step();
    ins(OP_SUB, 32'd20, 32'd3, 32'd0, 1'b0, 5'd6, 1'b1); step();
    chk("bp_ready_low", id_ready, 0);
    ins(OP_XOR, 32'hFF, 32'h0F, 32'd0, 1'b0, 5'd7, 1'b1); step();
    chk("bp_head_held", ex_result, 32'd11);
    id_valid = 1'b0; ex_ready = 1'b1;
    step();
    chk("bp_second", ex_result, 32'd17);
    step();

    // Taken BLT, wrong-path drop, then untaken BLTU.
    br(BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
    step();
    chk("blt_redirect", redirect_valid, 1);
    chk("blt_target", redirect_pc, 32'h120);
    ins(OP_ADD, 32'd100, 32'd0, 32'd1, 1'b1, 5'd9, 1'b1);
    step();
    chk("drop_ex_valid", ex_valid, 0);
    br(BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
    step();
    chk("bltu_not_taken", redirect_valid, 0);
    id_valid = 1'b0;
    step();

    // Flush while FULL with an offer present.
    ex_ready = 1'b0;
    ins(OP_OR, 32'h1, 32'h2, 32'd0, 1'b0, 5'd10, 1'b1); step();
    ins(OP_AND, 32'h3, 32'h6, 32'd0, 1'b0, 5'd11, 1'b1); step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_id_ready", id_ready, 1);
    // Flush kills a same-cycle taken branch.
    ins(OP_ADD, 32'h1, 32'h2, 32'd0, 1'b0, 5'd12, 1'b1); step();
    br(BR_BEQ, 32'd9, 32'd9, 32'h200, 32'h8);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_no_redirect", redirect_valid, 0);
    id_valid = 1'b0; ex_ready = 1'b1;
    step();

    // Asynchronous reset mid-cycle while FULL.
    ex_ready = 1'b0;
    ins(OP_ADD, 32'd7, 32'd0, 32'd8, 1'b1, 5'd13, 1'b1); step();
    br(BR_BNE, 32'd1, 32'd2, 32'h300, 32'h4); step();
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    mq.delete(); m_rv = 1'b0; m_pc = '0;
    step();
    rst_n = 1'b1; ex_ready = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      id_valid     = ($urandom % 4) != 0;
      id_alu_op    = 3'($urandom);
      id_rs1_val   = $urandom;
      id_rs2_val   = (($urandom % 4) == 0) ? id_rs1_val : $urandom;
      id_imm       = $urandom;
      id_use_imm   = 1'($urandom);
      id_is_branch = ($urandom % 4) == 0;
      id_br_type   = 3'($urandom);
      id_pc        = $urandom;
      id_rd        = 5'($urandom);
      id_wb_en     = 1'($urandom);
      ex_ready     = ($urandom % 3) != 0;
      flush        = ($urandom % 20) == 0;
      step();
    end
    flush = 1'b0; id_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
